// File: rtl/lock_pkg.sv
// lock_pkg: shared types and helpers for the combination-lock code player.
package lock_pkg;
  typedef logic [1:0] key_idx_t;
  localparam int CODE_LEN = 4;
  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS,
    S_GAP,
    S_WAIT_RES,
    S_DONE
  } player_state_e;
  function automatic logic [3:0] key_onehot(key_idx_t k);
    return 4'b0001 << k;
  endfunction
endpackage

// File: rtl/lock_cycle_counter.sv
// lock_cycle_counter: loadable down-counter with a zero flag, saturating at zero.
module lock_cycle_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         zero
);
  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && !zero) cnt <= cnt - 1'b1;
  end
  assign zero = cnt == '0;
endmodule

// File: rtl/lock_code_player.sv
// lock_code_player: plays a stored 4-digit code into the combination lock and reports its verdict.
module lock_code_player
  import lock_pkg::*;
#(
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lock_en,
  input  logic       start,
  input  logic [7:0] code,
  input  logic       y,
  input  logic       ny,
  output logic [3:0] keys,
  output logic       anykey,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       fail,
  output logic       timeout
);
  localparam int MAXC = GAP_CYCLES > TIMEOUT_CYCLES ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = MAXC > 1 ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] GAP_LD = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] TO_LD = CW'(TIMEOUT_CYCLES - 1);
  localparam key_idx_t LAST_IDX = key_idx_t'(CODE_LEN - 1);
  player_state_e state, state_d;
  logic [7:0] code_q;
  key_idx_t idx;
  logic cnt_load, cnt_dec, cnt_zero;
  logic [CW-1:0] cnt_ld_val, cnt;
  lock_cycle_counter #(.W(CW)) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .load    (cnt_load),
    .dec     (cnt_dec),
    .load_val(cnt_ld_val),
    .cnt     (cnt),
    .zero    (cnt_zero)
  );
  always_comb begin
    state_d    = state;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    cnt_ld_val = GAP_LD;
    case (state)
      S_IDLE:  state_d = start ? S_PRESS : S_IDLE;
      S_PRESS: begin
        cnt_load = lock_en;
        state_d  = lock_en ? S_GAP : S_PRESS;
      end
      S_GAP: begin
        cnt_dec    = !cnt_zero;
        cnt_load   = cnt_zero && idx == LAST_IDX;
        cnt_ld_val = TO_LD;
        state_d    = !cnt_zero ? S_GAP : idx == LAST_IDX ? S_WAIT_RES : S_PRESS;
      end
      S_WAIT_RES: begin
        cnt_dec = !(ny || y || cnt_zero);
        state_d = (ny || y || cnt_zero) ? S_DONE : S_WAIT_RES;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      code_q  <= '0;
      idx     <= '0;
      pass    <= 1'b0;
      fail    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state <= state_d;
      if (state == S_IDLE && start) begin
        code_q  <= code;
        idx     <= '0;
        pass    <= 1'b0;
        fail    <= 1'b0;
        timeout <= 1'b0;
      end
      if (state == S_GAP && cnt_zero && idx != LAST_IDX) idx <= idx + 2'd1;
      // ny outranks y so a lock asserting both is reported as a failure
      if (state == S_WAIT_RES) begin
        if (ny) fail <= 1'b1;
        else if (y) pass <= 1'b1;
        else if (cnt_zero) begin
          fail    <= 1'b1;
          timeout <= 1'b1;
        end
      end
    end
  end
  assign keys   = state == S_PRESS ? key_onehot(code_q[{idx, 1'b0} +: 2]) : 4'b0000;
  assign anykey = state == S_PRESS;
  assign busy   = state != S_IDLE;
  assign done   = state == S_DONE;
endmodule

// File: tb/tb_lock_code_player.sv
// tb_lock_code_player: scoreboard bench with a behavioural combination lock attached.
module tb_lock_code_player;
  logic clk = 1'b0, reset = 1'b1, lock_en = 1'b1, start = 1'b0;
  logic [7:0] code = '0;
  logic y, ny;
  logic [3:0] keys;
  logic anykey, busy, done, pass, fail, timeout;
  typedef struct {
    logic p, f, t;
    int   lat;
  } res_t;
  res_t rq[$];
  logic [3:0] kq[$];
  int n_chk = 0, n_pass = 0, cyc = 0, t0 = 0, en_per = 1, ph = 0;
  logic tie = 1'b0, ty = 1'b0, tny = 1'b0, lk_clr = 1'b0;
  logic [7:0] lk_code = 8'hE3;
  int lk_n = 0;
  logic lk_ok = 1'b1;

  lock_code_player dut (
    .clk(clk), .reset(reset), .lock_en(lock_en), .start(start), .code(code),
    .y(y), .ny(ny), .keys(keys), .anykey(anykey), .busy(busy), .done(done),
    .pass(pass), .fail(fail), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // lock model: four qualified presses, then y or ny held until cleared
  always @(posedge clk) begin
    if (reset || lk_clr) begin
      lk_n  <= 0;
      lk_ok <= 1'b1;
    end else if (lock_en && anykey && lk_n < 4) begin
      lk_ok <= lk_ok && keys == (4'b0001 << lk_code[2*lk_n +: 2]);
      lk_n  <= lk_n + 1;
    end
  end
  assign y  = tie ? ty : (lk_n == 4 && lk_ok);
  assign ny = tie ? tny : (lk_n == 4 && !lk_ok);

  always @(posedge clk) begin
    cyc++;
    #1;
    ph = (ph + 1) % en_per;
    lock_en = ph == 0;
  end

  always @(negedge clk) begin
    if (!reset && start && !busy) t0 = cyc;
    if (!reset && lock_en && anykey) begin
      if (kq.size() > 0) chk("key", keys, kq.pop_front());
      else chk("key_extra", keys, 0);
    end
    if (done) begin
      if (rq.size() > 0) begin
        res_t r;
        r = rq.pop_front();
        chk("verdict", {pass, fail, timeout}, {r.p, r.f, r.t});
        if (r.lat >= 0) chk("done_lat", cyc - t0, r.lat);
      end else chk("done_extra", done, 0);
    end
  end

  task automatic run(input logic [7:0] c, input int per, input logic tm, input logic a, input logic b,
                     input logic p, input logic f, input logic t, input int lat, input logic sid);
    res_t r;
    int n;
    r = '{p, f, t, lat};
    @(posedge clk);
    #2;
    en_per = per; tie = tm; ty = a; tny = b; lk_clr = 1'b1;
    @(posedge clk);
    #2 lk_clr = 1'b0;
    for (int i = 0; i < 4; i++) kq.push_back(4'b0001 << c[2*i +: 2]);
    rq.push_back(r);
    start = 1'b1; code = c;
    @(posedge clk);
    #2 start = 1'b0; code = 8'($urandom);
    @(negedge clk);
    chk("busy_after_start", busy, 1);
    n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_wait", done, 1);
    if (sid) begin
      start = 1'b1; code = 8'hFF;
    end
    @(posedge clk);
    #2 start = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("held", {pass, fail, timeout}, {p, f, t});
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("reset_outs", {busy, anykey, done, pass, fail, timeout, keys}, 0);
    run(8'hE3, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 22, 1'b1);
    run(8'h00, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 22, 1'b0);
    run(8'hE3, 3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1, 1'b0);
    chk("lock_presses", lk_n, 4);
    run(8'h1B, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 37, 1'b0);
    run(8'hE3, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 22, 1'b1);
    // abandoned sequence: a stray start mid-run, then reset in the second gap
    en_per = 1; tie = 1'b0;
    @(posedge clk);
    #2 lk_clr = 1'b1;
    @(posedge clk);
    #2 lk_clr = 1'b0;
    for (int i = 0; i < 4; i++) kq.push_back(4'b0001 << lk_code[2*i +: 2]);
    rq.push_back('{1'b1, 1'b0, 1'b0, 22});
    start = 1'b1; code = 8'hE3;
    @(posedge clk);
    #2 start = 1'b0;
    @(posedge clk);
    #2 start = 1'b1; code = 8'hFF;
    @(posedge clk);
    #2 start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    chk("mid_gap", {busy, anykey}, 2'b10);
    chk("presses_before_reset", kq.size(), 2);
    reset = 1'b1;
    kq.delete();
    rq.delete();
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("abort_outs", {busy, anykey, done, pass, fail, timeout, keys}, 0);
    run(8'hE3, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 22, 1'b0);
    @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("reset_clears_pass", {busy, done, pass, fail, timeout}, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/lock_code_player.md
# lock_code_player

Initiator-side driver for the 4-key combination-lock FSM. It plays a stored 4-digit code into the lock's `keys`/`anykey` inputs, one one-hot press per lock-enable cycle, with idle gaps between presses. It then waits for the lock's `y`/`ny` verdict and reports pass/fail. It sits between the top-level self-test/auto-unlock logic and the lock instance, sharing the lock's clock and `en` strobe.

## Interface
Parameters:
- `GAP_CYCLES`, default 4: clk cycles with keys released between presses; must be ≥1.
- `TIMEOUT_CYCLES`, default 16: clk cycles allowed for the verdict after the last gap; must be ≥1.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: reset is synchronous and active-high.
- `lock_en` in 1: the lock's `en` strobe; the lock advances only on cycles where it is high.
- `start` in 1: one-cycle request; ignored while `busy`.
- `code` in 8: four 2-bit key indices; digit0 = `[1:0]` is played first, digit3 = `[7:6]` last; sampled on an accepted `start`.
- `y` in 1: lock "correct" output.
- `ny` in 1: lock "wrong" output.
- `keys` out 4: one-hot key drive.
- `anykey` out 1: key-press strobe to the lock.
- `busy` out 1: high from the cycle after an accepted `start` until and including the DONE cycle.
- `done` out 1: one-cycle completion pulse.
- `pass` out 1: verdict correct; held until the next accepted `start`.
- `fail` out 1: verdict wrong or timeout; held until the next accepted `start`.
- `timeout` out 1: the fail was caused by timeout; held like `fail`.

## Operation
- Moore FSM with states IDLE, PRESS, GAP, WAIT_RES, DONE.
- Registers:
  - `code_q` (8b)
  - `idx` (2b)
  - down-counter `cnt`, sized for max(GAP_CYCLES, TIMEOUT_CYCLES)
- IDLE:
  - On `start`: latch `code_q`, set `idx`=0, clear `pass`/`fail`/`timeout`, go to PRESS.
- PRESS:
  - Drive `keys` = 1 << `code_q[2*idx+:2]`, `anykey`=1.
  - On a cycle with `lock_en`=1: load `cnt`=GAP_CYCLES-1, go to GAP.
  - The lock therefore sees exactly one qualified press per digit.
- GAP:
  - Drive `keys`=0, `anykey`=0; decrement `cnt`.
  - When `cnt`==0: if `idx`==3, load `cnt`=TIMEOUT_CYCLES-1 and go to WAIT_RES; else increment `idx` and go to PRESS.
- WAIT_RES:
  - `keys`=0, `anykey`=0. Checks in priority order:
    - `ny`=1 → `fail`=1, go to DONE.
    - `y`=1 (and `ny`=0) → `pass`=1, go to DONE.
    - `cnt`==0 → `fail`=1, `timeout`=1, go to DONE.
    - Otherwise decrement `cnt`.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `y` and `ny` both high is treated as fail (`ny` wins).
- `y`/`ny` are ignored outside WAIT_RES.
- `start` is ignored in every state except IDLE. A `start` in the DONE cycle is also ignored.
- Reset (any state, including mid-sequence): go to IDLE and set all outputs to 0 on the next edge. The partially entered code is abandoned, so the lock must also be reset or allowed to complete its own sequence.

## Timing
- Every output is a function of registered state only; no input-to-output combinational path.
- Accepted `start` at edge t: `busy`, `keys`, and `anykey` are valid from cycle t+1.
- Press duration = cycles until the first `lock_en`=1 in PRESS, inclusive. With `lock_en` tied high, each press lasts exactly 1 cycle.
- Gap = exactly GAP_CYCLES cycles.
- With `lock_en`=1 throughout, the last press is followed by GAP_CYCLES cycles; the lock's `y` is visible on the first WAIT_RES cycle.
- Full run with `lock_en`=1: 4·(1+GAP_CYCLES)+1+1 cycles from `start` to `done`. This is 22 cycles at the defaults.
- Timeout: `done` comes TIMEOUT_CYCLES+1 cycles after WAIT_RES entry.
- `pass`/`fail`/`timeout` update on the same edge that enters DONE, so they are valid together with `done`.

## Structure
- Package `lock_pkg`:
  - `key_idx_t` (2-bit)
  - `CODE_LEN`=4
  - `player_state_e` enum
  - function `key_onehot(key_idx_t)`
- One sub-module: `lock_cycle_counter`, a loadable down-counter with a zero flag, shared by the GAP and WAIT_RES phases.
- The FSM and output decode live in `lock_code_player`.

## Test plan
- `code`=8'hE3 (digits 3,0,2,3), `lock_en`=1, real lock attached → `keys` sequence 8,1,4,8 with one `anykey` cycle each; `pass`=1 and `done` pulse at cycle 22.
- `code`=8'h00, real lock → lock reaches NK4; `fail`=1, `timeout`=0.
- `lock_en` high only every 3rd cycle → each press held until a qualified cycle; `keys` 8,1,4,8 still seen exactly once each by the lock; `pass`=1.
- `y`/`ny` tied 0 → `fail`=1, `timeout`=1; `done` TIMEOUT_CYCLES+1=17 cycles after WAIT_RES entry.
- `start` pulsed mid-sequence, then `reset` asserted during the 2nd GAP → second `start` ignored; after reset, all outputs 0 and `busy`=0 the next cycle.
- `y`=`ny`=1 in WAIT_RES → `fail`=1, `pass`=0.
